// File: rtl/home_service_arbiter.sv
// ============================================================================
// home_service_arbiter : rotating-priority home service arbiter with
//                        thermostat hysteresis and fire-alarm preemption
// Revision: 1.0
// ============================================================================
`default_nettype none

module home_service_arbiter #(
  parameter int N_CH      = 5,
  parameter int TEMP_W    = 7,
  parameter int T_LOW     = 50,
  parameter int T_HIGH    = 70,
  parameter int HYST      = 2,
  parameter int DWELL     = 4,
  parameter int URGENT_CH = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_CH-2:0]   sens,
  input  logic [TEMP_W-1:0] temp,
  output logic [N_CH-1:0]   grant,
  output logic              heater,
  output logic              cooler,
  output logic [4:0]        display,
  output logic [15:0]       conflict_cnt
);

  localparam int c_ch_w = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TEMP_W:0]   c_cold_set = (TEMP_W+1)'(T_LOW);
  localparam logic [TEMP_W:0]   c_cold_clr = (TEMP_W+1)'(T_LOW + HYST);
  localparam logic [TEMP_W:0]   c_hot_set  = (TEMP_W+1)'(T_HIGH);
  localparam logic [TEMP_W:0]   c_hot_clr  = (TEMP_W+1)'(T_HIGH - HYST);
  localparam logic [c_ch_w-1:0] c_urg      = c_ch_w'(URGENT_CH);
  localparam logic [7:0]        c_dwell_ld = 8'(DWELL - 1);
  localparam logic [N_CH-1:0]   c_one      = {{(N_CH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_CH-1:0]     grant_q, grant_d;
  logic [c_ch_w-1:0]   last_ch_q, last_ch_d;
  logic [7:0]          dwell_q, dwell_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                cold_q, cold_d;
  logic                hot_q, hot_d;

  logic [TEMP_W:0]     w_temp;
  logic [N_CH-1:0]     w_req;
  logic [c_ch_w-1:0]   w_win;
  logic [c_ch_w-1:0]   w_sel_ch;
  logic                w_sel;
  logic                w_multi;
  logic                w_urg;
  logic                w_urg_held;

  // Descending search starting just below the last granted channel; the
  // last channel itself is reached only after every other one.
  function automatic logic [c_ch_w-1:0] f_pick(input logic [N_CH-1:0]   r,
                                               input logic [c_ch_w-1:0] last);
    logic [c_ch_w-1:0] idx;
    logic              found;
    f_pick = last;
    found  = 1'b0;
    for (int o = 1; o <= N_CH; o++) begin
      idx = c_ch_w'((int'(last) + N_CH - o) % N_CH);
      if (!found && r[idx]) begin
        f_pick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_temp = {1'b0, temp};

  always_comb begin
    cold_d = cold_q;
    hot_d  = hot_q;
    if (w_temp < c_cold_set)       cold_d = 1'b1;
    else if (w_temp >= c_cold_clr) cold_d = 1'b0;
    if (w_temp > c_hot_set)        hot_d  = 1'b1;
    else if (w_temp <= c_hot_clr)  hot_d  = 1'b0;
  end

  assign w_req      = {sens, cold_q | hot_q};
  assign w_win      = f_pick(w_req, last_ch_q);
  assign w_multi    = ($countones(w_req) > 1);
  assign w_urg      = w_req[URGENT_CH];
  assign w_urg_held = (last_ch_q == c_urg);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      last_ch_q <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      cold_q    <= 1'b0;
      hot_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_ch_q <= last_ch_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      cold_q    <= cold_d;
      hot_q     <= hot_d;
    end
  end

  // While serving, last_ch_q is the granted channel.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_ch_d = last_ch_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    w_sel     = 1'b0;
    w_sel_ch  = w_win;
    case (state_q)
      S_IDLE: begin
        if (w_urg) begin
          w_sel    = 1'b1;
          w_sel_ch = c_urg;
        end else if (|w_req) begin
          w_sel = 1'b1;
        end
      end
      S_SERVE: begin
        if (w_urg && !w_urg_held) begin
          w_sel    = 1'b1;
          w_sel_ch = c_urg;
        end else if (!w_req[last_ch_q]) begin
          if (|w_req) begin
            w_sel = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            dwell_d = '0;
          end
        end else if (dwell_q != 8'd0) begin
          dwell_d = dwell_q - 8'd1;
        end else if (!w_urg_held && w_multi) begin
          w_sel = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    if (w_sel) begin
      state_d   = S_SERVE;
      grant_d   = c_one << w_sel_ch;
      last_ch_d = w_sel_ch;
      dwell_d   = c_dwell_ld;
      if (w_multi && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end
  end

  assign grant        = grant_q;
  assign conflict_cnt = cnt_q;
  assign cooler       = grant_q[0] & hot_q;
  assign heater       = grant_q[0] & cold_q & ~hot_q;

  always_comb begin
    display = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) display = 5'(i + 1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_home_service_arbiter.sv
// ============================================================================
// tb_home_service_arbiter : scoreboard bench for home_service_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_home_service_arbiter;
  localparam int N     = 5;
  localparam int TW    = 7;
  localparam int TLOW  = 50;
  localparam int THIGH = 70;
  localparam int HY    = 2;
  localparam int DW    = 4;
  localparam int UC    = 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [N-2:0]  sens = '0;
  logic [TW-1:0] temp = 7'd60;
  logic [N-1:0]  grant;
  logic          heater;
  logic          cooler;
  logic [4:0]    display;
  logic [15:0]   conflict_cnt;

  home_service_arbiter #(
    .N_CH(N), .TEMP_W(TW), .T_LOW(TLOW), .T_HIGH(THIGH),
    .HYST(HY), .DWELL(DW), .URGENT_CH(UC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .sens(sens), .temp(temp),
    .grant(grant), .heater(heater), .cooler(cooler),
    .display(display), .conflict_cnt(conflict_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int g;
    int d;
    int h;
    int c;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference state: granted channel (-1 = none), rotation origin, dwell left.
  int m_g = -1, m_last = 0, m_dwell = 0, m_cnt = 0;
  bit m_cold = 1'b0, m_hot = 1'b0;

  function automatic int winner(bit [N-1:0] r);
    for (int o = 1; o <= N; o++) begin
      int c;
      c = (m_last - o + N) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit rst, input bit [N-2:0] s, input int t);
    bit [N-1:0] r;
    int nr;
    int sel;
    if (rst) begin
      m_g = -1; m_last = 0; m_dwell = 0; m_cnt = 0; m_cold = 0; m_hot = 0;
    end else begin
      r   = {s, m_cold | m_hot};
      nr  = $countones(r);
      sel = -1;
      if (m_g < 0) begin
        if (r[UC]) sel = UC;
        else if (nr > 0) sel = winner(r);
      end else if (r[UC] && m_g != UC) begin
        sel = UC;
      end else if (!r[m_g]) begin
        if (nr > 0) sel = winner(r);
        else begin m_g = -1; m_dwell = 0; end
      end else if (m_dwell > 0) begin
        m_dwell--;
      end else if (m_g != UC && nr > 1) begin
        sel = winner(r);
      end
      if (sel >= 0) begin
        m_g = sel; m_last = sel; m_dwell = DW - 1;
        if (nr >= 2 && m_cnt < 65535) m_cnt++;
      end
      if (t < TLOW) m_cold = 1;
      else if (t >= TLOW + HY) m_cold = 0;
      if (t > THIGH) m_hot = 1;
      else if (t <= THIGH - HY) m_hot = 0;
    end
  endtask

  task automatic step(input bit rst, input bit [N-2:0] s, input int t);
    exp_t e;
    @(posedge Clk);
    #2;
    Rst  = rst;
    sens = s;
    temp = 7'(t);
    model_edge(rst, s, t);
    e.g   = (m_g < 0) ? 0 : (1 << m_g);
    e.d   = m_g + 1;
    e.h   = (m_g == 0 && m_cold && !m_hot) ? 1 : 0;
    e.c   = (m_g == 0 && m_hot) ? 1 : 0;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant",        int'(grant), e.g);
        chk("onehot0",      int'($onehot0(grant)), 1);
        chk("display",      int'(display), e.d);
        chk("heater",       int'(heater), e.h);
        chk("cooler",       int'(cooler), e.c);
        chk("conflict_cnt", int'(conflict_cnt), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int t;
    bit [N-2:0] s;
    // Reset and quiet idle
    repeat (3)  step(1, 4'b0000, 60);
    repeat (10) step(0, 4'b0000, 60);
    // ch4 held, then cold at the same time
    repeat (10) step(0, 4'b1000, 45);
    // Hysteresis ramp on heater and cooler
    repeat (2) step(1, 4'b0000, 60);
    repeat (4) step(0, 4'b0000, 45);
    repeat (4) step(0, 4'b0000, 51);
    repeat (4) step(0, 4'b0000, 52);
    repeat (4) step(0, 4'b0000, 71);
    repeat (4) step(0, 4'b0000, 68);
    // Rotation among ch1, ch3, ch4
    repeat (2)  step(1, 4'b0000, 60);
    repeat (30) step(0, 4'b1101, 60);
    // Urgent preemption mid-dwell
    repeat (2)  step(1, 4'b0000, 60);
    repeat (2)  step(0, 4'b1000, 60);
    repeat (12) step(0, 4'b1010, 60);
    repeat (3)  step(0, 4'b1000, 60);
    // Reset pulse mid-service
    repeat (2) step(1, 4'b0000, 60);
    repeat (3) step(0, 4'b0001, 60);
    step(1, 4'b0001, 60);
    repeat (5) step(0, 4'b0001, 60);
    // Randomized traffic around the thresholds
    t = 60;
    s = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) t = $urandom_range(40, 80);
      else t = t + $urandom_range(0, 4) - 2;
      if (t < 40) t = 40;
      if (t > 80) t = 80;
      step(($urandom_range(0, 199) == 0), s, t);
    end
    repeat (3) @(posedge Clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/home_service_arbiter.md
HOME_SERVICE_ARBITER -- requirements
Module: home_service_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 5; total service channels, channel 0 = temperature, legal 2..16.
REQ-002 SHALL have parameter TEMP_W, default 7; temperature input width.
REQ-003 SHALL have parameters T_LOW, default 50, and T_HIGH, default 70; heater/cooler thresholds, degrees F, unsigned.
REQ-004 SHALL have parameter HYST, default 2; hysteresis band in degrees.
REQ-005 SHALL have parameter DWELL, default 4; minimum grant length in cycles, legal 1..255.
REQ-006 SHALL have parameter URGENT_CH, default 2; preempting channel (fire alarm), legal 1..N_CH-1.
REQ-007 SHALL have port Clk, input, 1; clock, all state on rising edge.
REQ-008 SHALL have port Rst, input, 1; synchronous, active-high reset.
REQ-009 SHALL have port sens, input, N_CH-1; discrete sensor requests, sens[i] drives channel i+1.
REQ-010 SHALL have port temp, input, TEMP_W; temperature reading, unsigned.
REQ-011 SHALL have port grant, output, N_CH; one-hot or zero serviced channel, registered.
REQ-012 SHALL have port heater, output, 1; high when grant[0] is set and cold flag is set.
REQ-013 SHALL have port cooler, output, 1; high when grant[0] is set and hot flag is set.
REQ-014 SHALL have port display, output, 5; 0 when idle, else granted channel index + 1.
REQ-015 SHALL have port conflict_cnt, output, 16; saturating count of arbitration decisions taken with two or more requesters.

Function
REQ-016 Cold flag SHALL set when temp < T_LOW and clear when temp >= T_LOW+HYST; it otherwise holds.
REQ-017 Hot flag SHALL set when temp > T_HIGH and clear when temp <= T_HIGH-HYST; it otherwise holds.
REQ-018 Both flags SHALL be registered; req[0] = cold|hot; req[i] = sens[i-1] for i >= 1.
REQ-019 The FSM SHALL have two states: IDLE (grant = 0) and SERVE (one grant bit set, dwell counter running).
REQ-020 Latency SHALL be one cycle: a request sampled at edge k produces grant at edge k+1. The temperature channel adds one extra cycle for its flag register.
REQ-021 IDLE -> SERVE SHALL occur when any req is set; the winner is chosen by the rotating search in REQ-022.
REQ-022 The rotating search SHALL start at last_ch-1 and descend, wrapping from 0 to N_CH-1; last_ch itself is checked last.
REQ-023 last_ch SHALL update on every grant change; its reset value is 0.
REQ-024 In SERVE, the dwell counter SHALL load DWELL-1 on grant and decrement to 0, saturating there.
REQ-025 In SERVE, if req[granted] drops, the FSM SHALL re-arbitrate next cycle: go to IDLE if no req is set, else grant the next winner. Dwell does not apply.
REQ-026 In SERVE with dwell = 0, req[granted] still set and another req set, the FSM SHALL rotate to the next winner next cycle.
REQ-027 In SERVE with dwell = 0 and no other req set, the grant SHALL hold.
REQ-028 Urgent preemption: if req[URGENT_CH] is set and URGENT_CH is not granted, the FSM SHALL grant URGENT_CH next cycle regardless of dwell or rotation order.
REQ-029 An urgent grant SHALL NOT be rotated away by dwell expiry while req[URGENT_CH] stays set.
REQ-030 conflict_cnt SHALL increment once per cycle in which a new grant is selected with popcount(req) >= 2, saturating at 65535.
REQ-031 grant SHALL never have more than one bit set.
REQ-032 heater and cooler SHALL never both be high; if both flags are set, which cannot occur when T_LOW+HYST <= T_HIGH-HYST, cooler wins.
REQ-033 display SHALL be combinational from grant: index of the set bit plus 1, or 0.

Reset
REQ-034 On Rst at a clock edge: grant=0, state=IDLE, dwell=0, last_ch=0, cold=0, hot=0, conflict_cnt=0, so heater=cooler=display=0.
REQ-035 Rst asserted mid-service SHALL drop the grant at that edge, with no completion of dwell.
REQ-036 The first arbitration after reset SHALL search from N_CH-1 downward.

Verification
REQ-037 Reset, sens=0, temp=60 -> grant=0, display=0, heater=cooler=0 for 10 cycles.
REQ-038 sens[3] (ch4) held, then temp=45 at the same time -> ch4 holds 4 cycles, ch0 granted at cycle 5, heater=1, display=1, conflict_cnt=1.
REQ-039 temp ramps 45->51->52 -> heater holds at 51 and drops after 52 is sampled (hysteresis); temp 71 -> cooler; then 68 -> cooler drops.
REQ-040 Channels 1,3,4 held continuously -> grant order 4,3,1,4,3,1…, each 4 cycles, conflict_cnt increments per rotation.
REQ-041 ch4 served with dwell=3, then sens[1] (ch2) rises -> grant=ch2 next cycle, and ch2 stays granted while held despite pending ch4.
REQ-042 ch1 granted, Rst pulsed one cycle -> grant=0 at that edge, and after release ch1 is re-granted from search start N_CH-1.
